// File: rtl/psram_channel_bram_if.sv
// Command/response bundle of one PSRAM channel. The RAM controller drives the
// master side; the BRAM responder sits on the slave side.
interface psram_channel_bram_if #(
    parameter int ADDR_WIDTH = 21
);
    // Handshake: cmd_en is a one-cycle strobe and is taken only in a cycle where
    // busy=0 (busy rises on the following cycle); a strobe seen while busy=1 is
    // discarded and latches cmd_dropped. rd_data is meaningful only while
    // rd_data_valid=1; beats of a burst arrive on consecutive cycles.
    logic                  cmd;
    logic                  cmd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wr_data;
    logic [3:0]            data_mask;
    logic [31:0]           rd_data;
    logic                  rd_data_valid;
    logic                  busy;
    logic                  cmd_dropped;
    logic                  init_calib;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy, cmd_dropped, init_calib
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy, cmd_dropped, init_calib
    );
endinterface

// File: rtl/psram_channel_bram.sv
// BRAM-backed stand-in for one PSRAM channel: same command protocol, burst
// length, read latency and calibration delay as the real device.
module psram_channel_bram #(
    parameter int ADDR_WIDTH   = 21,
    parameter int MEM_AW       = 12,
    parameter int BURST        = 4,
    parameter int RD_LATENCY   = 8,
    parameter int WR_RECOVERY  = 2,
    parameter int CALIB_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    psram_channel_bram_if.slave bus,
    output logic [2:0]          o_dbg_state
);
    localparam int CNT_MAX = (BURST > RD_LATENCY)
                           ? ((BURST > WR_RECOVERY) ? BURST : WR_RECOVERY)
                           : ((RD_LATENCY > WR_RECOVERY) ? RD_LATENCY : WR_RECOVERY);
    localparam int CW   = $clog2(CNT_MAX + 1);
    localparam int CALW = $clog2(CALIB_CYCLES + 1);

    typedef enum logic [2:0] {
        S_CALIB   = 3'd0,
        S_IDLE    = 3'd1,
        S_WRITE   = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_DATA = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    state_t              r_state;
    logic [CALW-1:0]     r_calib_cnt;
    logic [CW-1:0]       r_cnt;
    logic [MEM_AW-1:0]   r_addr;
    logic                r_init_calib;
    logic                r_rd_valid;
    logic                r_dropped;
    logic [31:0]         r_rd_data;
    logic [31:0]         r_mem [0:(2**MEM_AW)-1];

    logic                w_we;
    logic                w_re;
    logic [MEM_AW-1:0]   w_waddr;
    logic [MEM_AW-1:0]   w_raddr;
    logic [MEM_AW-1:0]   w_beat_addr;
    logic                w_unused_addr;

    assign w_beat_addr   = r_addr + MEM_AW'(r_cnt);
    assign w_unused_addr = ^bus.addr[ADDR_WIDTH-1:MEM_AW];

    // Beat 0 of a write goes straight from the bus in the acceptance cycle;
    // a write beat coinciding with reset is suppressed so truncation is clean.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.addr[MEM_AW-1:0];
        if (!reset) begin
            if (r_state == S_IDLE && bus.cmd_en && bus.cmd) begin
                w_we = 1'b1;
            end else if (r_state == S_WRITE) begin
                w_we    = 1'b1;
                w_waddr = w_beat_addr;
            end
        end
    end

    // Reads are issued one cycle ahead of the beat they produce.
    always_comb begin
        w_re    = 1'b0;
        w_raddr = r_addr;
        if (r_state == S_RD_WAIT && r_cnt == CW'(RD_LATENCY - 2)) begin
            w_re = 1'b1;
        end else if (r_state == S_RD_DATA && r_cnt != CW'(BURST)) begin
            w_re    = 1'b1;
            w_raddr = w_beat_addr;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && !bus.data_mask[i]) begin
                r_mem[w_waddr][8*i +: 8] <= bus.wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_re) begin
            r_rd_data <= r_mem[w_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_CALIB;
            r_calib_cnt  <= '0;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_init_calib <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            if (bus.cmd_en && r_state != S_IDLE) begin
                r_dropped <= 1'b1;
            end
            case (r_state)
                S_CALIB: begin
                    if (r_calib_cnt == CALW'(CALIB_CYCLES - 1)) begin
                        r_state      <= S_IDLE;
                        r_init_calib <= 1'b1;
                    end else begin
                        r_calib_cnt <= r_calib_cnt + CALW'(1);
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_en) begin
                        r_addr <= bus.addr[MEM_AW-1:0];
                        if (bus.cmd) begin
                            if (BURST > 1) begin
                                r_state <= S_WRITE;
                                r_cnt   <= CW'(1);
                            end else if (WR_RECOVERY > 0) begin
                                r_state <= S_RECOVER;
                                r_cnt   <= '0;
                            end
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_cnt == CW'(BURST - 1)) begin
                        r_cnt   <= '0;
                        r_state <= (WR_RECOVERY > 0) ? S_RECOVER : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == CW'(WR_RECOVERY - 1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == CW'(RD_LATENCY - 2)) begin
                        r_state    <= S_RD_DATA;
                        r_cnt      <= CW'(1);
                        r_rd_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RD_DATA: begin
                    // r_cnt counts beats already issued; all done once it hits BURST.
                    if (r_cnt == CW'(BURST)) begin
                        r_state    <= S_IDLE;
                        r_rd_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_CALIB;
            endcase
        end
    end

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.init_calib    = r_init_calib;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_rd_valid;
    assign bus.cmd_dropped   = r_dropped;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_psram_channel_bram.sv
// Randomized bench for psram_channel_bram against a word-array memory model
// with burst timing computed from the command acceptance cycle.
module tb_psram_channel_bram;
    localparam int B         = 4;
    localparam int L         = 8;
    localparam int WR_REC    = 2;
    localparam int CALIB     = 64;
    localparam int MEM_WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  unused_dbg_state;
    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    psram_channel_bram_if #(.ADDR_WIDTH(21)) bus ();

    psram_channel_bram #(
        .ADDR_WIDTH(21), .MEM_AW(12), .BURST(B), .RD_LATENCY(L),
        .WR_RECOVERY(WR_REC), .CALIB_CYCLES(CALIB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .o_dbg_state(unused_dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive_idle();
        bus.cmd_en    = 1'b0;
        bus.cmd       = 1'($urandom_range(0, 1));
        bus.addr      = 21'($urandom);
        bus.wr_data   = $urandom;
        bus.data_mask = 4'($urandom_range(0, 15));
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (!m[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clk);
            drive_idle();
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic calib_run(input bit poke);
        drive_idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_init_calib", 32'(bus.init_calib), 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_rd_valid", 32'(bus.rd_data_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_dropped", 32'(bus.cmd_dropped), 32'd0);
        reset = 1'b0;
        for (int c = 1; c <= CALIB; c++) begin
            @(negedge clk);
            drive_idle();
            if (poke && c == 10) begin
                bus.cmd_en    = 1'b1;
                bus.cmd       = 1'b1;
                bus.data_mask = 4'h0;
            end
            check("calib_init", 32'(bus.init_calib), 32'(c == CALIB));
            check("calib_busy", 32'(bus.busy), 32'(c < CALIB));
        end
        check("calib_dropped", 32'(bus.cmd_dropped), 32'(poke));
    endtask

    task automatic do_write(input logic [20:0] a, input logic [127:0] d, input logic [15:0] m);
        int rel;
        wait_idle();
        for (int k = 0; k < B; k++) begin
            if (k > 0) begin
                @(negedge clk);
                check("wr_busy", 32'(bus.busy), 32'd1);
            end
            drive_idle();
            if (k == 0) begin
                bus.cmd_en = 1'b1;
                bus.cmd    = 1'b1;
                bus.addr   = a;
            end
            bus.wr_data   = d[32*k +: 32];
            bus.data_mask = m[4*k +: 4];
            model_write((int'(a) + k) % MEM_WORDS, d[32*k +: 32], m[4*k +: 4]);
        end
        rel = B;
        @(negedge clk);
        drive_idle();
        while (bus.busy && rel < B + WR_REC + 32) begin
            @(negedge clk);
            drive_idle();
            rel++;
        end
        check("wr_busy_fall", 32'(rel), 32'(B + WR_REC));
    endtask

    task automatic do_read(input logic [20:0] a, input int inject_at, input logic [20:0] inj_addr);
        logic [31:0] last = '0;
        logic [31:0] w;
        bit          exp_v;
        wait_idle();
        drive_idle();
        bus.cmd_en = 1'b1;
        bus.cmd    = 1'b0;
        bus.addr   = a;
        for (int k = 0; k < B; k++) exp_q.push_back(model_mem[(int'(a) + k) % MEM_WORDS]);
        for (int rel = 1; rel <= L + B; rel++) begin
            @(negedge clk);
            drive_idle();
            if (rel == inject_at) begin
                bus.cmd_en    = 1'b1;
                bus.cmd       = 1'b1;
                bus.addr      = inj_addr;
                bus.data_mask = 4'h0;
            end
            exp_v = (rel >= L) && (rel < L + B);
            check("rd_valid", 32'(bus.rd_data_valid), 32'(exp_v));
            check("rd_busy", 32'(bus.busy), 32'(rel < L + B));
            if (bus.rd_data_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_extra_beat", 32'd1, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("rd_data", bus.rd_data, w);
                    last = w;
                end
            end
        end
        check("rd_hold", bus.rd_data, last);
        check("rd_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [20:0] a;
        reset = 1'b1;
        drive_idle();

        calib_run(1'b1);
        calib_run(1'b0);

        for (int i = 0; i < MEM_WORDS; i += B) begin
            do_write(21'(i) | (21'($urandom_range(0, 511)) << 12), rand128(), 16'h0000);
        end

        do_write(21'h10, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'h0000);
        do_read(21'h10, 0, 21'h0);

        do_write(21'h20, {rand128()} & {96'h0, 32'h0} | {rand128()} & {96'hffffffff_ffffffff_ffffffff, 32'h0}
                 | {96'h0, 32'hAABBCCDD}, 16'h0000);
        do_write(21'h20, {rand128()} & {96'hffffffff_ffffffff_ffffffff, 32'h0} | {96'h0, 32'h11223344}, 16'hfff5);
        do_read(21'h20, 0, 21'h0);

        do_write(21'hFFE, rand128(), 16'h0000);
        do_read(21'hFFE, 0, 21'h0);
        do_read(21'h000, 0, 21'h0);
        do_write(21'h1FFFFE, rand128(), 16'h0000);
        do_read(21'h000FFE, 0, 21'h0);

        check("no_false_drop", 32'(bus.cmd_dropped), 32'd0);
        do_read(21'h40, 3, 21'h41);
        check("busy_drop", 32'(bus.cmd_dropped), 32'd1);
        do_read(21'h40, 0, 21'h0);

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 21'h1FF000 & 21'($urandom) | 21'(12'hFFC + 12'($urandom_range(0, 3)));
                default: a = 21'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, rand128(), 16'($urandom));
            end else begin
                do_read(a, 0, 21'h0);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                drive_idle();
            end
        end

        wait_idle();
        drive_idle();
        bus.cmd_en = 1'b1;
        bus.cmd    = 1'b0;
        bus.addr   = 21'h10;
        for (int rel = 1; rel <= 10; rel++) begin
            @(negedge clk);
            drive_idle();
            if (rel == 8 || rel == 9) check("mid_valid", 32'(bus.rd_data_valid), 32'd1);
            if (rel == 9) reset = 1'b1;
            if (rel == 10) begin
                check("mid_rst_valid", 32'(bus.rd_data_valid), 32'd0);
                check("mid_rst_calib", 32'(bus.init_calib), 32'd0);
                check("mid_rst_busy", 32'(bus.busy), 32'd1);
            end
        end
        calib_run(1'b0);
        do_read(21'h10, 0, 21'h0);
        do_read(21'hFFE, 0, 21'h0);
        do_read(21'h20, 0, 21'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
